// File: rtl/iob_uart_fifo_core.sv
// Buffered UART engine: TX and RX FIFOs around a serializer/deserializer pair,
// with runtime parity and stop-bit selection, CTS/RTS flow control and sticky errors.

module iob_uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         cke,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the registered level, so a pop cannot make room for a same-cycle push.
  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (cke) begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cke && do_push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

module iob_uart_fifo_core #(
  parameter int UART_DATA_W = 8,
  parameter int FIFO_ADDR_W = 4,
  parameter int DIV_W       = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   cke_i,
  input  logic                   rst_soft_i,
  input  logic                   tx_en_i,
  input  logic                   rx_en_i,
  input  logic [DIV_W-1:0]       bit_duration_i,
  input  logic [1:0]             parity_i,
  input  logic                   stop2_i,
  input  logic [UART_DATA_W-1:0] tx_data_i,
  input  logic                   tx_wen_i,
  output logic                   tx_full_o,
  output logic [FIFO_ADDR_W:0]   tx_level_o,
  output logic                   tx_busy_o,
  output logic [UART_DATA_W-1:0] rx_data_o,
  input  logic                   rx_ren_i,
  output logic                   rx_empty_o,
  output logic [FIFO_ADDR_W:0]   rx_level_o,
  output logic                   rx_overrun_o,
  output logic                   rx_parity_err_o,
  output logic                   rx_frame_err_o,
  input  logic                   err_clr_i,
  output logic                   txd_o,
  input  logic                   rxd_i,
  input  logic                   cts_i,
  output logic                   rts_o
);
  localparam logic [3:0]           LAST_BIT = 4'(UART_DATA_W - 1);
  localparam logic [FIFO_ADDR_W:0] RTS_MAX  = (FIFO_ADDR_W + 1)'((2 ** FIFO_ADDR_W) - 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  tx_state_t              tx_state, tx_next;
  logic [DIV_W-1:0]       tx_cnt, tx_div;
  logic [UART_DATA_W-1:0] tx_shift, tx_head;
  logic [3:0]             tx_idx;
  logic                   tx_stop_idx, tx_stop2, tx_par_en, tx_par_bit;
  logic                   tx_empty, tx_can_start, tx_bit_end, tx_load;

  rx_state_t              rx_state, rx_next;
  logic [DIV_W-1:0]       rx_cnt, rx_div, rx_target;
  logic [UART_DATA_W-1:0] rx_shift;
  logic [3:0]             rx_idx;
  logic                   rx_par_en, rx_par_odd, rx_par_exp;
  logic                   rxd_meta, rxd_sync, rxd_prev;
  logic                   rx_fall, rx_sample, rx_push, rx_full;
  logic                   set_overrun, set_parity, set_frame;

  iob_uart_fifo #(.W(UART_DATA_W), .AW(FIFO_ADDR_W)) tx_fifo (
    .clk(clk_i), .arst(arst_i), .cke(cke_i), .flush(rst_soft_i),
    .push(tx_wen_i), .wdata(tx_data_i), .pop(tx_load), .rdata(tx_head),
    .full(tx_full_o), .empty(tx_empty), .level(tx_level_o)
  );

  iob_uart_fifo #(.W(UART_DATA_W), .AW(FIFO_ADDR_W)) rx_fifo (
    .clk(clk_i), .arst(arst_i), .cke(cke_i), .flush(rst_soft_i),
    .push(rx_push), .wdata(rx_shift), .pop(rx_ren_i), .rdata(rx_data_o),
    .full(rx_full), .empty(rx_empty_o), .level(rx_level_o)
  );

  assign tx_can_start = tx_en_i && cts_i && !tx_empty;
  assign tx_bit_end   = (tx_cnt == tx_div - 1'b1);
  assign tx_busy_o    = (tx_state != TX_IDLE);

  // tx_load pops the FIFO head and latches the frame configuration, including back-to-back restarts.
  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE:   if (tx_can_start) begin tx_next = TX_START; tx_load = 1'b1; end
      TX_START:  if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:   if (tx_bit_end && tx_idx == LAST_BIT) tx_next = tx_par_en ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
      TX_STOP: begin
        if (tx_bit_end && tx_stop_idx == tx_stop2) begin
          if (tx_can_start) begin tx_next = TX_START; tx_load = 1'b1; end
          else tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)          tx_state <= TX_IDLE;
    else if (rst_soft_i) tx_state <= TX_IDLE;
    else if (cke_i)      tx_state <= tx_next;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tx_cnt <= '0; tx_div <= '0; tx_shift <= '0; tx_idx <= '0;
      tx_stop_idx <= 1'b0; tx_stop2 <= 1'b0; tx_par_en <= 1'b0; tx_par_bit <= 1'b0;
      txd_o <= 1'b1;
    end else if (rst_soft_i) begin
      tx_cnt <= '0; tx_div <= '0; tx_shift <= '0; tx_idx <= '0;
      tx_stop_idx <= 1'b0; tx_stop2 <= 1'b0; tx_par_en <= 1'b0; tx_par_bit <= 1'b0;
      txd_o <= 1'b1;
    end else if (cke_i) begin
      if (tx_load) begin
        tx_cnt      <= '0;
        tx_div      <= bit_duration_i;
        tx_shift    <= tx_head;
        tx_idx      <= '0;
        tx_stop_idx <= 1'b0;
        tx_stop2    <= stop2_i;
        tx_par_en   <= (parity_i == 2'b01) || (parity_i == 2'b10);
        tx_par_bit  <= (^tx_head) ^ (parity_i == 2'b10);
        txd_o       <= 1'b0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_bit_end) begin
          tx_cnt <= '0;
          case (tx_state)
            TX_START: begin
              txd_o    <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
            TX_DATA: begin
              if (tx_idx == LAST_BIT) begin
                txd_o <= tx_par_en ? tx_par_bit : 1'b1;
              end else begin
                txd_o    <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_idx   <= tx_idx + 1'b1;
              end
            end
            TX_PARITY: txd_o <= 1'b1;
            TX_STOP: begin
              tx_stop_idx <= 1'b1;
              txd_o       <= 1'b1;
            end
            default: txd_o <= 1'b1;
          endcase
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  // The start bit is resampled at half a bit, every later sample one full bit after the previous one.
  assign rx_fall    = rxd_prev && !rxd_sync;
  assign rx_target  = (rx_state == RX_START) ? ((rx_div >> 1) - 1'b1) : (rx_div - 1'b1);
  assign rx_sample  = (rx_cnt == rx_target);
  assign rx_par_exp = (^rx_shift) ^ rx_par_odd;
  assign set_overrun = rx_push && rx_full;

  always_comb begin
    rx_next    = rx_state;
    rx_push    = 1'b0;
    set_parity = 1'b0;
    set_frame  = 1'b0;
    if (!rx_en_i) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE:  if (rx_fall) rx_next = RX_START;
        RX_START: if (rx_sample) rx_next = rxd_sync ? RX_IDLE : RX_DATA;
        RX_DATA:  if (rx_sample && rx_idx == LAST_BIT) rx_next = rx_par_en ? RX_PARITY : RX_STOP;
        RX_PARITY: begin
          if (rx_sample) begin
            rx_next    = RX_STOP;
            set_parity = (rxd_sync != rx_par_exp);
          end
        end
        RX_STOP: begin
          if (rx_sample) begin
            rx_next   = RX_IDLE;
            rx_push   = rxd_sync;
            set_frame = !rxd_sync;
          end
        end
        default: rx_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)          rx_state <= RX_IDLE;
    else if (rst_soft_i) rx_state <= RX_IDLE;
    else if (cke_i)      rx_state <= rx_next;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rxd_meta <= 1'b1; rxd_sync <= 1'b1; rxd_prev <= 1'b1;
      rx_cnt <= '0; rx_div <= '0; rx_shift <= '0; rx_idx <= '0;
      rx_par_en <= 1'b0; rx_par_odd <= 1'b0;
    end else if (rst_soft_i) begin
      rxd_meta <= 1'b1; rxd_sync <= 1'b1; rxd_prev <= 1'b1;
      rx_cnt <= '0; rx_div <= '0; rx_shift <= '0; rx_idx <= '0;
      rx_par_en <= 1'b0; rx_par_odd <= 1'b0;
    end else if (cke_i) begin
      rxd_meta <= rxd_i;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      if (rx_state == RX_IDLE) begin
        rx_cnt     <= '0;
        rx_idx     <= '0;
        rx_div     <= bit_duration_i;
        rx_par_en  <= (parity_i == 2'b01) || (parity_i == 2'b10);
        rx_par_odd <= (parity_i == 2'b10);
      end else if (rx_sample) begin
        rx_cnt <= '0;
        if (rx_state == RX_DATA) begin
          rx_shift <= {rxd_sync, rx_shift[UART_DATA_W-1:1]};
          rx_idx   <= rx_idx + 1'b1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rx_overrun_o <= 1'b0; rx_parity_err_o <= 1'b0; rx_frame_err_o <= 1'b0; rts_o <= 1'b0;
    end else if (rst_soft_i) begin
      rx_overrun_o <= 1'b0; rx_parity_err_o <= 1'b0; rx_frame_err_o <= 1'b0; rts_o <= 1'b0;
    end else if (cke_i) begin
      rx_overrun_o    <= set_overrun | (rx_overrun_o & ~err_clr_i);
      rx_parity_err_o <= set_parity | (rx_parity_err_o & ~err_clr_i);
      rx_frame_err_o  <= set_frame | (rx_frame_err_o & ~err_clr_i);
      rts_o           <= rx_en_i && (rx_level_o <= RTS_MAX);
    end
  end
endmodule

// File: tb/tb_iob_uart_fifo_core.sv
// Directed bench for iob_uart_fifo_core: TX framing, loopback, error injection,
// overrun/RTS, CTS flow control, soft reset and RX abort.

module tb_iob_uart_fifo_core;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DIVW = 16;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic            cke = 1'b1;
  logic            rst_soft = 1'b0;
  logic            tx_en = 1'b0;
  logic            rx_en = 1'b0;
  logic [DIVW-1:0] bit_duration = 16'd16;
  logic [1:0]      parity = 2'b00;
  logic            stop2 = 1'b0;
  logic [DW-1:0]   tx_data = '0;
  logic            tx_wen = 1'b0;
  logic            tx_full;
  logic [AW:0]     tx_level;
  logic            tx_busy;
  logic [DW-1:0]   rx_data;
  logic            rx_ren = 1'b0;
  logic            rx_empty;
  logic [AW:0]     rx_level;
  logic            rx_overrun, rx_parity_err, rx_frame_err;
  logic            err_clr = 1'b0;
  logic            txd, rxd, cts = 1'b1, rts;
  logic            loop = 1'b0;
  logic            tb_rxd = 1'b1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;
  assign rxd = loop ? txd : tb_rxd;

  iob_uart_fifo_core #(.UART_DATA_W(DW), .FIFO_ADDR_W(AW), .DIV_W(DIVW)) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .rst_soft_i(rst_soft),
    .tx_en_i(tx_en), .rx_en_i(rx_en), .bit_duration_i(bit_duration),
    .parity_i(parity), .stop2_i(stop2), .tx_data_i(tx_data), .tx_wen_i(tx_wen),
    .tx_full_o(tx_full), .tx_level_o(tx_level), .tx_busy_o(tx_busy),
    .rx_data_o(rx_data), .rx_ren_i(rx_ren), .rx_empty_o(rx_empty), .rx_level_o(rx_level),
    .rx_overrun_o(rx_overrun), .rx_parity_err_o(rx_parity_err), .rx_frame_err_o(rx_frame_err),
    .err_clr_i(err_clr), .txd_o(txd), .rxd_i(rxd), .cts_i(cts), .rts_o(rts)
  );

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
  endtask

  task automatic pushTx(input logic [7:0] b);
    tx_data = b;
    tx_wen  = 1'b1;
    waitCycles(1);
    tx_wen  = 1'b0;
  endtask

  task automatic popRx();
    rx_ren = 1'b1;
    waitCycles(1);
    rx_ren = 1'b0;
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    waitCycles(1);
    err_clr = 1'b0;
  endtask

  // Bit-bangs one frame onto the RX line, followed by two idle bit times.
  task automatic applyStimulus(input logic [7:0] data, input logic par_en, input logic par_bit,
                               input logic stop_val, input int div);
    tb_rxd = 1'b0;
    waitCycles(div);
    for (int i = 0; i < 8; i++) begin
      tb_rxd = data[i];
      waitCycles(div);
    end
    if (par_en) begin
      tb_rxd = par_bit;
      waitCycles(div);
    end
    tb_rxd = stop_val;
    waitCycles(div);
    tb_rxd = 1'b1;
    waitCycles(2 * div);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] frame_bits;
    int         busy_cycles;
    int         busy_falls;
    logic       prev_busy;

    waitCycles(2);
    checkOutput("rst_txd", txd, 1);
    checkOutput("rst_rts", rts, 0);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_full", tx_full, 0);
    checkOutput("rst_empty", rx_empty, 1);
    checkOutput("rst_tx_level", tx_level, 0);
    checkOutput("rst_rx_level", rx_level, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    checkOutput("rst_overrun", rx_overrun, 0);
    checkOutput("rst_parity", rx_parity_err, 0);
    checkOutput("rst_frame", rx_frame_err, 0);
    arst = 1'b0;
    waitCycles(1);

    // 8N1 at 16 cycles per bit, byte 0xA5
    tx_en = 1'b1;
    frame_bits = {1'b1, 8'hA5, 1'b0};
    pushTx(8'hA5);
    checkOutput("a5_level_after_push", tx_level, 1);
    checkOutput("a5_txd_before_start", txd, 1);
    checkOutput("a5_busy_before_start", tx_busy, 0);
    waitCycles(1);
    checkOutput("a5_level_after_pop", tx_level, 0);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("a5_bit%0d_first", k), txd, 32'(frame_bits[k]));
      checkOutput($sformatf("a5_busy%0d", k), tx_busy, 1);
      waitCycles(15);
      checkOutput($sformatf("a5_bit%0d_last", k), txd, 32'(frame_bits[k]));
      waitCycles(1);
    end
    checkOutput("a5_busy_end", tx_busy, 0);
    checkOutput("a5_txd_end", txd, 1);

    // Loopback 8E2 at 8 cycles per bit, held by CTS until all three bytes are queued
    bit_duration = 16'd8;
    parity = 2'b01;
    stop2 = 1'b1;
    rx_en = 1'b1;
    loop = 1'b1;
    cts = 1'b0;
    waitCycles(1);
    checkOutput("lb_rts_on", rts, 1);
    pushTx(8'h3C);
    pushTx(8'h81);
    pushTx(8'hFF);
    waitCycles(20);
    checkOutput("cts_hold_txd", txd, 1);
    checkOutput("cts_hold_busy", tx_busy, 0);
    checkOutput("cts_hold_level", tx_level, 3);
    cts = 1'b1;
    busy_cycles = 0;
    busy_falls = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_busy) busy_cycles++;
      if (prev_busy && !tx_busy) busy_falls++;
      prev_busy = tx_busy;
      waitCycles(1);
    end
    checkOutput("lb_busy_cycles", 32'(busy_cycles), 288);
    checkOutput("lb_busy_falls", 32'(busy_falls), 1);
    checkOutput("lb_rx_level", rx_level, 3);
    checkOutput("lb_parity_err", rx_parity_err, 0);
    checkOutput("lb_frame_err", rx_frame_err, 0);
    checkOutput("lb_overrun", rx_overrun, 0);
    checkOutput("lb_byte0", rx_data, 8'h3C);
    popRx();
    checkOutput("lb_byte1", rx_data, 8'h81);
    checkOutput("lb_level_after_pop", rx_level, 2);
    popRx();
    checkOutput("lb_byte2", rx_data, 8'hFF);
    popRx();
    checkOutput("lb_empty", rx_empty, 1);
    checkOutput("lb_data_empty", rx_data, 0);

    // Error injection with RX in odd parity mode
    loop = 1'b0;
    tx_en = 1'b0;
    parity = 2'b10;
    stop2 = 1'b0;
    waitCycles(2);
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b1, 8);
    checkOutput("perr_level", rx_level, 1);
    checkOutput("perr_data", rx_data, 8'h01);
    checkOutput("perr_flag", rx_parity_err, 1);
    checkOutput("perr_no_frame", rx_frame_err, 0);
    popRx();
    applyStimulus(8'h55, 1'b1, 1'b1, 1'b0, 8);
    checkOutput("ferr_discarded", rx_level, 0);
    checkOutput("ferr_flag", rx_frame_err, 1);
    checkOutput("ferr_parity_sticky", rx_parity_err, 1);
    pulseErrClr();
    checkOutput("clr_parity", rx_parity_err, 0);
    checkOutput("clr_frame", rx_frame_err, 0);

    // Overrun and RTS: 17 frames with no pops, 8N1 at 4 cycles per bit
    parity = 2'b00;
    bit_duration = 16'd4;
    waitCycles(2);
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(8'(k), 1'b0, 1'b0, 1'b1, 4);
      checkOutput($sformatf("ovr_level%0d", k), rx_level, (k < 16) ? k : 16);
      checkOutput($sformatf("ovr_rts%0d", k), rts, (k <= 14) ? 1 : 0);
      checkOutput($sformatf("ovr_flag%0d", k), rx_overrun, (k == 17) ? 1 : 0);
    end
    for (int k = 1; k <= 16; k++) begin
      checkOutput($sformatf("ovr_data%0d", k), rx_data, k);
      popRx();
    end
    checkOutput("ovr_drained", rx_empty, 1);
    waitCycles(1);
    checkOutput("ovr_rts_back", rts, 1);
    pulseErrClr();
    checkOutput("ovr_clr", rx_overrun, 0);

    // CTS dropped mid-frame: current frame completes, next one is held
    rx_en = 1'b0;
    tx_en = 1'b1;
    cts = 1'b0;
    pushTx(8'h0F);
    pushTx(8'hF0);
    waitCycles(5);
    checkOutput("ctsd_level_held", tx_level, 2);
    checkOutput("ctsd_txd_held", txd, 1);
    cts = 1'b1;
    waitCycles(1);
    checkOutput("ctsd_start_txd", txd, 0);
    checkOutput("ctsd_start_busy", tx_busy, 1);
    checkOutput("ctsd_start_level", tx_level, 1);
    waitCycles(4);
    cts = 1'b0;
    waitCycles(35);
    checkOutput("ctsd_last_stop_busy", tx_busy, 1);
    checkOutput("ctsd_last_stop_txd", txd, 1);
    waitCycles(1);
    checkOutput("ctsd_done_busy", tx_busy, 0);
    checkOutput("ctsd_done_level", tx_level, 1);
    waitCycles(50);
    checkOutput("ctsd_no_restart_busy", tx_busy, 0);
    checkOutput("ctsd_no_restart_txd", txd, 1);

    // Soft reset mid-frame with five bytes still queued
    for (int k = 0; k < 5; k++) pushTx(8'h00);
    checkOutput("srst_level_before", tx_level, 6);
    cts = 1'b1;
    waitCycles(11);
    checkOutput("srst_mid_txd", txd, 0);
    checkOutput("srst_mid_busy", tx_busy, 1);
    checkOutput("srst_mid_level", tx_level, 5);
    rst_soft = 1'b1;
    waitCycles(1);
    rst_soft = 1'b0;
    checkOutput("srst_txd", txd, 1);
    checkOutput("srst_level", tx_level, 0);
    checkOutput("srst_busy", tx_busy, 0);
    checkOutput("srst_full", tx_full, 0);
    waitCycles(10);
    checkOutput("srst_stays_idle", tx_busy, 0);

    // rx_en dropped during a frame: nothing is stored
    tx_en = 1'b0;
    bit_duration = 16'd8;
    rx_en = 1'b1;
    waitCycles(2);
    tb_rxd = 1'b0;
    waitCycles(8);
    tb_rxd = 1'b1;
    waitCycles(8);
    rx_en = 1'b0;
    waitCycles(1);
    checkOutput("abort_rts_off", rts, 0);
    waitCycles(20);
    rx_en = 1'b1;
    waitCycles(60);
    checkOutput("abort_level", rx_level, 0);
    checkOutput("abort_empty", rx_empty, 1);
    checkOutput("abort_frame_err", rx_frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
